// File: rtl/irrigation_cycle_ctrl_if.sv
// Handshake/status bundle between the irrigation cycle sequencer and its
// environment (user inputs, sensors, counter chain, valve driver).
interface irrigation_cycle_ctrl_if #(
    parameter int W = 6
) ();
    logic         sec_tick;
    logic         start;
    logic         mode;
    logic         Us;
    logic         alin;
    logic         abort;
    logic         cnt_en;
    logic         cnt_clr;
    logic         valve_open;
    logic         busy;
    logic         done;
    logic         fault;
    logic [W-1:0] remaining;
    logic [2:0]   state;

    // Environment side: drives commands and sensors, observes status.
    modport master (
        output sec_tick, start, mode, Us, alin, abort,
        input  cnt_en, cnt_clr, valve_open, busy, done, fault, remaining, state
    );

    // Sequencer side.
    modport slave (
        input  sec_tick, start, mode, Us, alin, abort,
        output cnt_en, cnt_clr, valve_open, busy, done, fault, remaining, state
    );
endinterface

// File: rtl/irrigation_cycle_ctrl.sv
// Irrigation cycle sequencer: loads a watering duration, counts it down on the
// 1 Hz tick with the valve open, pauses on low supply, ends early on wet soil,
// and latches a fault if supply stays low for too long.
module irrigation_cycle_ctrl #(
    parameter int W           = 6,
    parameter int DRIP_SECS   = 15,
    parameter int SPRINK_SECS = 9,
    parameter int MAX_PAUSE   = 30
) (
    input  logic                   clk,
    input  logic                   clear,
    irrigation_cycle_ctrl_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_PAUSE  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [W-1:0] remaining_q, remaining_d;
    logic [W-1:0] pause_cnt_q, pause_cnt_d;
    logic [W-1:0] pause_inc;
    logic         cnt_en_q, cnt_en_d;
    logic         cnt_clr_q, cnt_clr_d;
    logic         valve_q, valve_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         fault_q, fault_d;

    // Pause counter stops at all-ones instead of wrapping.
    assign pause_inc = (pause_cnt_q == '1) ? pause_cnt_q : pause_cnt_q + W'(1);

    // Next-state logic; priority inside RUN/PAUSE is abort > Us > alin > tick.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pause_cnt_d = pause_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pause_cnt_d = '0;
                    if (bus.Us) begin
                        state_d = S_FINISH;          // soil already wet: skip watering
                    end else begin
                        state_d     = S_START;
                        remaining_d = bus.mode ? W'(SPRINK_SECS) : W'(DRIP_SECS);
                    end
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (bus.abort) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (bus.Us) begin
                    state_d = S_FINISH;              // early finish keeps remaining
                end else if (bus.alin) begin
                    state_d     = S_PAUSE;
                    pause_cnt_d = '0;
                end else if (bus.sec_tick) begin
                    if (remaining_q != '0) remaining_d = remaining_q - W'(1);
                    if (remaining_q == W'(1)) state_d = S_FINISH;
                end
            end
            S_PAUSE: begin
                if (bus.abort) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end else if (bus.Us) begin
                    state_d = S_FINISH;
                end else if (!bus.alin) begin
                    state_d     = S_RUN;             // tick on the resume edge is dropped
                    pause_cnt_d = '0;
                end else if (bus.sec_tick) begin
                    pause_cnt_d = pause_inc;
                    if (pause_inc >= W'(MAX_PAUSE)) state_d = S_FAULT;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_FAULT: begin
                if (bus.abort) begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                remaining_d = '0;
                pause_cnt_d = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        cnt_en_d  = (state_d == S_RUN);
        valve_d   = (state_d == S_RUN);
        cnt_clr_d = (state_d == S_START) || (state_d == S_FINISH);
        done_d    = (state_d == S_FINISH);
        fault_d   = (state_d == S_FAULT);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            pause_cnt_q <= '0;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            valve_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pause_cnt_q <= pause_cnt_d;
            cnt_en_q    <= cnt_en_d;
            cnt_clr_q   <= cnt_clr_d;
            valve_q     <= valve_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.remaining  = remaining_q;
    assign bus.cnt_en     = cnt_en_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign bus.valve_open = valve_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;

endmodule

// File: tb/tb_irrigation_cycle_ctrl.sv
// Table-driven bench for irrigation_cycle_ctrl: one vector per clock, outputs
// compared one time unit after the rising edge.
module tb_irrigation_cycle_ctrl;

    typedef struct {
        string      name;
        logic       clr, start, mode, tick, us, alin, abort;
        logic [2:0] st;
        logic [5:0] rem;
        logic       valve, en, cc, dn, ft;
    } vec_t;

    logic clk;
    logic clear;
    irrigation_cycle_ctrl_if #(.W(6)) bus ();

    irrigation_cycle_ctrl dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs[200];
    int   nvec = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic vec_t mk(string name,
                                logic clr, logic start, logic mode, logic tick,
                                logic us, logic alin, logic abort,
                                logic [2:0] st, logic [5:0] rem,
                                logic valve, logic en, logic cc, logic dn, logic ft);
        vec_t v;
        v.name = name; v.clr = clr; v.start = start; v.mode = mode; v.tick = tick;
        v.us = us; v.alin = alin; v.abort = abort; v.st = st; v.rem = rem;
        v.valve = valve; v.en = en; v.cc = cc; v.dn = dn; v.ft = ft;
        return v;
    endfunction

    task automatic add(string name,
                       logic clr, logic start, logic mode, logic tick,
                       logic us, logic alin, logic abort,
                       logic [2:0] st, logic [5:0] rem,
                       logic valve, logic en, logic cc, logic dn, logic ft);
        vecs[nvec] = mk(name, clr, start, mode, tick, us, alin, abort,
                        st, rem, valve, en, cc, dn, ft);
        nvec++;
    endtask

    // Drive one vector, clock once, compare every output.
    task automatic apply(input vec_t v);
        logic exp_busy;
        @(negedge clk);
        clear        = v.clr;
        bus.start    = v.start;
        bus.mode     = v.mode;
        bus.sec_tick = v.tick;
        bus.Us       = v.us;
        bus.alin     = v.alin;
        bus.abort    = v.abort;
        @(posedge clk);
        #1;
        exp_busy = (v.st != 3'd0);
        n_checks++;
        if (bus.state === v.st && bus.remaining === v.rem && bus.valve_open === v.valve &&
            bus.cnt_en === v.en && bus.cnt_clr === v.cc && bus.done === v.dn &&
            bus.fault === v.ft && bus.busy === exp_busy) begin
            n_pass++;
            $display("ok   %s: st=%0d rem=%0d valve=%b en=%b clr=%b done=%b fault=%b busy=%b",
                     v.name, bus.state, bus.remaining, bus.valve_open, bus.cnt_en,
                     bus.cnt_clr, bus.done, bus.fault, bus.busy);
        end else begin
            $display("FAIL %s: got st=%0d rem=%0d valve=%b en=%b clr=%b done=%b fault=%b busy=%b, want st=%0d rem=%0d valve=%b en=%b clr=%b done=%b fault=%b busy=%b",
                     v.name, bus.state, bus.remaining, bus.valve_open, bus.cnt_en,
                     bus.cnt_clr, bus.done, bus.fault, bus.busy,
                     v.st, v.rem, v.valve, v.en, v.cc, v.dn, v.ft, exp_busy);
        end
    endtask

    initial begin
        clear = 1'b1; bus.start = 1'b0; bus.mode = 1'b0; bus.sec_tick = 1'b0;
        bus.Us = 1'b0; bus.alin = 1'b0; bus.abort = 1'b0;

        //   name          clr st md tk us al ab | st rem  vl en cc dn ft
        // Sprinkler cycle, 9 ticks to done; ticks in IDLE/START ignored.
        add("reset",        1, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
        add("idle_tick",    0, 0, 0, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
        add("spk_start",    0, 1, 1, 0, 0, 0, 0,  1,  9,  0, 0, 1, 0, 0);
        add("start_tick",   0, 0, 0, 1, 0, 0, 0,  2,  9,  1, 1, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add("spk_tick",  0, 0, 0, 1, 0, 0, 0,  2, 6'(9 - i), 1, 1, 0, 0, 0);
        add("spk_done",     0, 0, 0, 1, 0, 0, 0,  4,  0,  0, 0, 1, 1, 0);
        add("spk_idle",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
        add("idle_tick2",   0, 0, 0, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
        // Drip cycle with a 3-tick supply pause; resume-edge tick dropped.
        add("drp_start",    0, 1, 0, 0, 0, 0, 0,  1, 15,  0, 0, 1, 0, 0);
        add("drp_run",      0, 0, 0, 0, 0, 0, 0,  2, 15,  1, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            add("drp_tick",  0, 0, 0, 1, 0, 0, 0,  2, 6'(15 - i), 1, 1, 0, 0, 0);
        add("drp_pause",    0, 0, 0, 0, 0, 1, 0,  3, 10,  0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            add("pause_tick", 0, 0, 0, 1, 0, 1, 0,  3, 10,  0, 0, 0, 0, 0);
        add("resume",       0, 0, 0, 1, 0, 0, 0,  2, 10,  1, 1, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            add("drp_tick2", 0, 0, 0, 1, 0, 0, 0,  2, 6'(10 - i), 1, 1, 0, 0, 0);
        add("drp_done",     0, 0, 0, 1, 0, 0, 0,  4,  0,  0, 0, 1, 1, 0);
        add("drp_idle",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
        // Wet soil at start: skip straight to FINISH.
        add("wet_start",    0, 1, 0, 0, 1, 0, 0,  4,  0,  0, 0, 1, 1, 0);
        add("wet_idle",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
        // Wet soil mid-run: early done, remaining kept.
        add("mw_start",     0, 1, 1, 0, 0, 0, 0,  1,  9,  0, 0, 1, 0, 0);
        add("mw_run",       0, 0, 0, 0, 0, 0, 0,  2,  9,  1, 1, 0, 0, 0);
        add("mw_tick",      0, 0, 0, 1, 0, 0, 0,  2,  8,  1, 1, 0, 0, 0);
        add("mw_tick",      0, 0, 0, 1, 0, 0, 0,  2,  7,  1, 1, 0, 0, 0);
        add("mw_wet",       0, 0, 0, 1, 1, 0, 0,  4,  7,  0, 0, 1, 1, 0);
        add("mw_idle",      0, 0, 0, 0, 0, 0, 0,  0,  7,  0, 0, 0, 0, 0);
        // Abort and tick on the same edge: no decrement, no done.
        add("ab_start",     0, 1, 1, 0, 0, 0, 0,  1,  9,  0, 0, 1, 0, 0);
        add("ab_run",       0, 0, 0, 0, 0, 0, 0,  2,  9,  1, 1, 0, 0, 0);
        add("ab_tick",      0, 0, 0, 1, 0, 0, 0,  2,  8,  1, 1, 0, 0, 0);
        add("ab_abort",     0, 0, 0, 1, 0, 0, 1,  0,  0,  0, 0, 0, 0, 0);
        // Wet soil while paused: Us beats alin.
        add("pw_start",     0, 1, 1, 0, 0, 0, 0,  1,  9,  0, 0, 1, 0, 0);
        add("pw_run",       0, 0, 0, 0, 0, 0, 0,  2,  9,  1, 1, 0, 0, 0);
        add("pw_pause",     0, 0, 0, 0, 0, 1, 0,  3,  9,  0, 0, 0, 0, 0);
        add("pw_wet",       0, 0, 0, 1, 1, 1, 0,  4,  9,  0, 0, 1, 1, 0);
        add("pw_idle",      0, 0, 0, 0, 0, 0, 0,  0,  9,  0, 0, 0, 0, 0);
        // Clear mid-run at remaining=4 overrides start/tick.
        add("cl_start",     0, 1, 0, 0, 0, 0, 0,  1, 15,  0, 0, 1, 0, 0);
        add("cl_run",       0, 0, 0, 0, 0, 0, 0,  2, 15,  1, 1, 0, 0, 0);
        for (int i = 1; i <= 11; i++)
            add("cl_tick",   0, 0, 0, 1, 0, 0, 0,  2, 6'(15 - i), 1, 1, 0, 0, 0);
        add("cl_clear",     1, 1, 0, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
        add("cl_after",     0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);

        for (int i = 0; i < nvec; i++) apply(vecs[i]);

        // Supply low for MAX_PAUSE ticks -> FAULT; only abort leaves it.
        apply(mk("ft_start",  0, 1, 0, 0, 0, 0, 0,  1, 15,  0, 0, 1, 0, 0));
        apply(mk("ft_run",    0, 0, 0, 0, 0, 0, 0,  2, 15,  1, 1, 0, 0, 0));
        apply(mk("ft_pause",  0, 0, 0, 0, 0, 1, 0,  3, 15,  0, 0, 0, 0, 0));
        for (int i = 1; i <= 29; i++)
            apply(mk("ft_wait", 0, 0, 0, 1, 0, 1, 0,  3, 15,  0, 0, 0, 0, 0));
        apply(mk("ft_fault",  0, 0, 0, 1, 0, 1, 0,  5, 15,  0, 0, 0, 0, 1));
        apply(mk("ft_hold",   0, 1, 0, 1, 0, 0, 0,  5, 15,  0, 0, 0, 0, 1));
        apply(mk("ft_abort",  0, 0, 0, 0, 0, 0, 1,  0,  0,  0, 0, 0, 0, 0));
        apply(mk("ft_idle",   0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0));

        // start held high: re-arms after one IDLE clock; ignored outside IDLE.
        apply(mk("ra_skip1",  0, 1, 0, 0, 1, 0, 0,  4,  0,  0, 0, 1, 1, 0));
        apply(mk("ra_idle",   0, 1, 0, 0, 1, 0, 0,  0,  0,  0, 0, 0, 0, 0));
        apply(mk("ra_skip2",  0, 1, 0, 0, 1, 0, 0,  4,  0,  0, 0, 1, 1, 0));
        apply(mk("ra_idle2",  0, 1, 1, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0));
        apply(mk("ra_start",  0, 1, 1, 0, 0, 0, 0,  1,  9,  0, 0, 1, 0, 0));
        apply(mk("ra_run",    0, 1, 0, 0, 0, 0, 0,  2,  9,  1, 1, 0, 0, 0));
        apply(mk("ra_abort",  0, 0, 0, 0, 0, 0, 1,  0,  0,  0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
